// File: rtl/scaler_stage.sv
// Binary scaler chain advanced by each falling edge of FS01 (rising FS01_n).
// Emits registered per-bit rise/fall strobes and a wrap strobe for each increment.
module scaler_stage #(
  parameter int NSTAGES = 16
) (
  input  logic               CLOCK,
  input  logic               SIM_RST,
  input  logic               FS01_n,
  input  logic               SCLCLR,
  input  logic               SCLHLD,
  output logic [NSTAGES-1:0] FS_n,
  output logic [NSTAGES-1:0] FA,
  output logic [NSTAGES-1:0] FB,
  output logic               SCLOVF
);

  logic               fs01_q;
  logic [NSTAGES-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [NSTAGES-1:0] fa_reg, fa_next, fb_reg, fb_next;
  logic               ovf_reg, ovf_next;
  logic               advance, incr;

  // fs01_q resets high so a steady-high FS01_n at release is not an advance
  assign advance = FS01_n & ~fs01_q;
  assign incr    = advance & ~SCLCLR & ~SCLHLD;
  assign cnt_inc = cnt_reg + {{(NSTAGES-1){1'b0}}, 1'b1};

  generate
    for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_edge
      assign fa_next[gi] = incr & ~cnt_reg[gi] &  cnt_inc[gi];
      assign fb_next[gi] = incr &  cnt_reg[gi] & ~cnt_inc[gi];
    end
  endgenerate

  assign ovf_next = incr & (&cnt_reg);

  // Clear wins over both hold and advance; discarded advances are not remembered
  always_comb begin
    cnt_next = cnt_reg;
    if (SCLCLR)
      cnt_next = '0;
    else if (incr)
      cnt_next = cnt_inc;
  end

  always_ff @(posedge CLOCK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      fs01_q  <= 1'b1;
      cnt_reg <= '0;
      fa_reg  <= '0;
      fb_reg  <= '0;
      ovf_reg <= 1'b0;
    end else begin
      fs01_q  <= FS01_n;
      cnt_reg <= cnt_next;
      fa_reg  <= fa_next;
      fb_reg  <= fb_next;
      ovf_reg <= ovf_next;
    end
  end

  assign FS_n   = ~cnt_reg;
  assign FA     = fa_reg;
  assign FB     = fb_reg;
  assign SCLOVF = ovf_reg;

endmodule

// File: tb/tb_scaler_stage.sv
// Directed bench for scaler_stage: a 16-stage chain plus a 4-stage chain on the
// same inputs so the wrap behaviour can be reached in a short run.
module tb_scaler_stage;

  logic        CLOCK = 1'b0;
  logic        SIM_RST, FS01_n, SCLCLR, SCLHLD;
  logic [15:0] fs_n, fa, fb;
  logic        sclovf;
  logic [3:0]  fs_n_s, fa_s, fb_s;
  logic        sclovf_s;

  int vec_count = 0;
  int err_count = 0;

  scaler_stage #(.NSTAGES(16)) dut (
    .CLOCK(CLOCK), .SIM_RST(SIM_RST), .FS01_n(FS01_n), .SCLCLR(SCLCLR), .SCLHLD(SCLHLD),
    .FS_n(fs_n), .FA(fa), .FB(fb), .SCLOVF(sclovf)
  );

  scaler_stage #(.NSTAGES(4)) dut_s (
    .CLOCK(CLOCK), .SIM_RST(SIM_RST), .FS01_n(FS01_n), .SCLCLR(SCLCLR), .SCLHLD(SCLHLD),
    .FS_n(fs_n_s), .FA(fa_s), .FB(fb_s), .SCLOVF(sclovf_s)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // One low cycle then a rising FS01_n sampled at the following edge
  task automatic advance_once();
    FS01_n = 1'b0;
    tick();
    FS01_n = 1'b1;
    tick();
  endtask

  task automatic check_quiet(input string tag);
    check_vec(tag, {fa, fb, 15'd0, sclovf}, 32'd0);
  endtask

  initial begin
    SIM_RST = 1'b0;
    FS01_n  = 1'b1;
    SCLCLR  = 1'b0;
    SCLHLD  = 1'b0;
    #3;
    check_vec("reset_fs_n", {16'd0, fs_n}, 32'h0000FFFF);
    check_quiet("reset_strobes");
    tick();
    tick();
    #2 SIM_RST = 1'b1;

    // Steady-high FS01_n after release: no advance
    for (int i = 0; i < 10; i++) begin
      tick();
      check_quiet("idle_strobes");
    end
    check_vec("idle_fs_n", {16'd0, fs_n}, 32'h0000FFFF);

    // Three FS01 periods, 4 low / 4 high
    for (int p = 0; p < 3; p++) begin
      FS01_n = 1'b0;
      repeat (4) tick();
      FS01_n = 1'b1;
      tick();
      case (p)
        0: begin check_vec("p0_fa", fa, 32'h0001); check_vec("p0_fb", fb, 32'h0000); end
        1: begin check_vec("p1_fa", fa, 32'h0002); check_vec("p1_fb", fb, 32'h0001); end
        default: begin check_vec("p2_fa", fa, 32'h0001); check_vec("p2_fb", fb, 32'h0000); end
      endcase
      tick();
      check_quiet("period_strobe_len");
      repeat (2) tick();
    end
    check_vec("period_fs_n", {16'd0, fs_n}, 32'h0000FFFC);
    check_vec("period_fs_n_s", {28'd0, fs_n_s}, 32'h0000000C);

    // Hold across two advance events
    SCLHLD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      advance_once();
      check_quiet("hold_strobes");
    end
    SCLHLD = 1'b0;
    tick();
    check_vec("hold_fs_n", {16'd0, fs_n}, 32'h0000FFFC);
    advance_once();
    check_vec("post_hold_fs_n", {16'd0, fs_n}, 32'h0000FFFB);
    check_vec("post_hold_fa", fa, 32'h0004);
    check_vec("post_hold_fb", fb, 32'h0003);
    advance_once();
    check_vec("cnt5_fs_n", {16'd0, fs_n}, 32'h0000FFFA);
    check_vec("cnt5_fa", fa, 32'h0001);

    // Clear coincident with an advance at CNT=5
    FS01_n = 1'b0;
    tick();
    FS01_n = 1'b1;
    SCLCLR = 1'b1;
    tick();
    SCLCLR = 1'b0;
    check_vec("clr_fs_n", {16'd0, fs_n}, 32'h0000FFFF);
    check_quiet("clr_strobes");
    tick();
    check_quiet("clr_strobes_after");

    // Run to 15, then wrap the 4-stage chain
    for (int i = 0; i < 15; i++) advance_once();
    check_vec("pre_wrap_fs_n", {16'd0, fs_n}, 32'h0000FFF0);
    check_vec("pre_wrap_fs_n_s", {28'd0, fs_n_s}, 32'h00000000);
    advance_once();
    check_vec("wrap_fs_n", {16'd0, fs_n}, 32'h0000FFEF);
    check_vec("wrap_fa", fa, 32'h0010);
    check_vec("wrap_fb", fb, 32'h000F);
    check_vec("wrap_ovf", {31'd0, sclovf}, 32'd0);
    check_vec("wrap_fs_n_s", {28'd0, fs_n_s}, 32'h0000000F);
    check_vec("wrap_fa_s", {28'd0, fa_s}, 32'h00000000);
    check_vec("wrap_fb_s", {28'd0, fb_s}, 32'h0000000F);
    check_vec("wrap_ovf_s", {31'd0, sclovf_s}, 32'd1);
    tick();
    check_vec("wrap_ovf_s_len", {31'd0, sclovf_s}, 32'd0);
    check_vec("wrap_fb_s_len", {28'd0, fb_s}, 32'd0);

    // Clear, count to 0x1233, then reset while the 0x1234 strobe is pending
    SCLCLR = 1'b1;
    tick();
    SCLCLR = 1'b0;
    check_vec("clr2_fs_n", {16'd0, fs_n}, 32'h0000FFFF);
    for (int i = 0; i < 16'h1233; i++) advance_once();
    check_vec("pre_rst_fs_n", {16'd0, fs_n}, 32'h0000EDCC);
    FS01_n = 1'b0;
    tick();
    FS01_n = 1'b1;
    @(posedge CLOCK);
    #1;
    check_vec("rst_pend_fs_n", {16'd0, fs_n}, 32'h0000EDCB);
    check_vec("rst_pend_fa", fa, 32'h0004);
    check_vec("rst_pend_fb", fb, 32'h0003);
    #2 SIM_RST = 1'b0;
    #1;
    check_vec("async_rst_fs_n", {16'd0, fs_n}, 32'h0000FFFF);
    check_quiet("async_rst_strobes");
    @(negedge CLOCK);
    SIM_RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_quiet("post_rst_strobes");
    end
    check_vec("post_rst_fs_n", {16'd0, fs_n}, 32'h0000FFFF);
    advance_once();
    check_vec("resume_fs_n", {16'd0, fs_n}, 32'h0000FFFE);
    check_vec("resume_fa", fa, 32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
